// File: rtl/diagnosis_conf_regs_if.sv
// diagnosis_conf_regs_if: debug NoC flit stream carrying configuration-write packets
interface diagnosis_conf_regs_if #(
    parameter int FW = 18
);
    logic [FW-1:0] flit;
    logic          valid;
    logic          ready;
    modport master (output flit, output valid, input ready);
    modport slave (input flit, input valid, output ready);
endinterface

// File: rtl/diagnosis_conf_regs.sv
// diagnosis_conf_regs: assembles NoC config writes in a shadow file and commits them atomically to conf_mem
module diagnosis_conf_regs #(
    parameter int         DBG_NOC_DATA_WIDTH      = 16,
    parameter int         DBG_NOC_FLIT_TYPE_WIDTH = 2,
    parameter int         CONF_WORDS              = 48,
    parameter logic [3:0] CONF_CLASS              = 4'h3
) (
    input  logic                        clk,
    input  logic                        rst,
    diagnosis_conf_regs_if.slave        dbgnoc_in,
    input  logic                        err_clr,
    output logic [16*CONF_WORDS-1:0]    conf_mem,
    output logic                        conf_update,
    output logic                        conf_err
);
    localparam int          FW  = DBG_NOC_DATA_WIDTH + DBG_NOC_FLIT_TYPE_WIDTH;
    localparam int          AW  = $clog2(CONF_WORDS);
    localparam logic [15:0] LIM = 16'(CONF_WORDS);
    localparam logic [1:0]  T_PAY = 2'b00, T_HDR = 2'b01, T_LST = 2'b10, T_SGL = 2'b11;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, DROP, COMMIT} state_t;

    state_t                         state;
    state_t                         hdr_state;
    logic [15:0]                    addr;
    logic [CONF_WORDS-1:0][15:0]    shadow;
    logic [CONF_WORDS-1:0][15:0]    shadow_wr;
    logic [CONF_WORDS-1:0][15:0]    conf_q;
    logic [FW-1:0]                  flit;
    logic [1:0]                     typ;
    logic [15:0]                    dat;
    logic                           ready;
    logic                           fire;
    logic                           in_range;
    logic                           is_wr;
    logic                           trunc;
    logic                           err_set;

    assign flit            = dbgnoc_in.flit;
    assign typ             = flit[FW-1:FW-2];
    assign dat             = flit[15:0];
    assign ready           = !rst && state != COMMIT;
    assign dbgnoc_in.ready = ready;
    assign fire            = dbgnoc_in.valid && ready;
    assign in_range        = addr < LIM;
    assign is_wr           = fire && state == DATA && (typ == T_PAY || typ == T_LST);
    assign trunc           = fire && (state == ADDR || state == DATA) && (typ == T_HDR || typ == T_SGL);
    assign err_set         = (fire && state == IDLE && (typ == T_PAY || typ == T_LST)) || trunc || (is_wr && !in_range);
    assign hdr_state       = dat[15:12] == CONF_CLASS ? ADDR : DROP;
    assign conf_mem        = conf_q;

    // shadow image including the word carried by the current flit, so LAST can commit in the same edge
    always_comb begin
        shadow_wr = shadow;
        if (is_wr && in_range) shadow_wr[addr[AW-1:0]] = dat;
    end

    // packet FSM, shadow file and atomic commit of the active configuration
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= '0;
            shadow      <= '0;
            conf_q      <= '0;
            conf_update <= 1'b0;
            conf_err    <= 1'b0;
        end else begin
            conf_update <= 1'b0;
            conf_err    <= err_set || (conf_err && !err_clr);
            shadow      <= trunc ? conf_q : shadow_wr;
            case (state)
                IDLE: if (fire && typ == T_HDR) state <= hdr_state;
                ADDR, DATA: if (fire) begin
                    if (typ == T_HDR) state <= hdr_state;
                    else if (typ == T_SGL) state <= IDLE;
                    else if (state == ADDR) begin
                        addr  <= typ == T_PAY ? dat : addr;
                        state <= typ == T_PAY ? DATA : IDLE;
                    end else begin
                        addr <= &addr ? addr : addr + 16'd1;
                        if (typ == T_LST) begin
                            state       <= COMMIT;
                            conf_q      <= shadow_wr;
                            conf_update <= 1'b1;
                        end
                    end
                end
                DROP: if (fire && typ == T_LST) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_diagnosis_conf_regs.sv
// tb_diagnosis_conf_regs: directed packets with a commit scoreboard for diagnosis_conf_regs
module tb_diagnosis_conf_regs;
    localparam int W = 48;
    localparam logic [1:0] PL = 2'b00, HD = 2'b01, LS = 2'b10;
    typedef logic [W-1:0][15:0] img_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              err_clr = 1'b0;
    logic [16*W-1:0]   conf_mem;
    logic              conf_update;
    logic              conf_err;
    img_t              exp_q[$];
    int                vectors = 0;
    int                miscompares = 0;
    bit                gaps = 1'b0;

    diagnosis_conf_regs_if #(.FW(18)) nif ();

    diagnosis_conf_regs dut (
        .clk(clk),
        .rst(rst),
        .dbgnoc_in(nif),
        .err_clr(err_clr),
        .conf_mem(conf_mem),
        .conf_update(conf_update),
        .conf_err(conf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [16*W-1:0] act, input logic [16*W-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic send(input logic [1:0] t, input logic [15:0] d);
        int n = 0;
        if (gaps && $urandom_range(0, 1) == 1) begin
            nif.valid = 1'b0;
            @(negedge clk);
        end
        nif.flit  = {t, d};
        nif.valid = 1'b1;
        while (!nif.ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) chk("ready timeout", 0, 1);
        @(negedge clk);
        nif.valid = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    // scoreboard monitor: every conf_update must match the next queued image
    initial forever begin
        @(negedge clk);
        if (conf_update) begin
            if (exp_q.size() == 0) chk("spurious conf_update", 1, 0);
            else chk("conf_mem commit", conf_mem, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        img_t e;
        e = '0;
        nif.valid = 1'b0;
        nif.flit  = '0;
        repeat (3) @(negedge clk);
        chk("reset ready", nif.ready, 0);
        chk("reset conf_mem", conf_mem, 0);
        chk("reset conf_err", conf_err, 0);
        chk("reset conf_update", conf_update, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready after reset", nif.ready, 1);

        e[2] = 16'hABCD;
        e[3] = 16'h1234;
        exp_q.push_back(e);
        send(HD, 16'h3000); send(PL, 16'h0002); send(PL, 16'hABCD); send(LS, 16'h1234);
        chk("update latency", conf_update, 1);
        chk("commit ready low", nif.ready, 0);
        chk("word3 at commit", conf_mem[63:48], 16'h1234);
        @(negedge clk);
        chk("ready after commit", nif.ready, 1);
        chk("update pulse width", conf_update, 0);

        send(HD, 16'h5000); send(PL, 16'h1111); send(PL, 16'h2222); send(PL, 16'h3333); send(LS, 16'h4444);
        @(negedge clk);
        chk("drop conf_mem", conf_mem, e);
        chk("drop conf_err", conf_err, 0);

        e[46] = 16'h1111;
        e[47] = 16'h2222;
        exp_q.push_back(e);
        send(HD, 16'h3000); send(PL, 16'd46); send(PL, 16'h1111); send(PL, 16'h2222); send(LS, 16'h3333);
        @(negedge clk);
        chk("out of range err", conf_err, 1);
        pulse_clr();
        chk("err_clr", conf_err, 0);

        e[0] = 16'h0001;
        exp_q.push_back(e);
        send(HD, 16'h3000); send(PL, 16'd5); send(PL, 16'hBEEF);
        send(HD, 16'h3000); send(PL, 16'd0); send(LS, 16'h0001);
        @(negedge clk);
        chk("truncation err", conf_err, 1);
        chk("word5 discarded", conf_mem[95:80], 16'h0000);
        pulse_clr();

        send(PL, 16'h0000);
        chk("stray payload err", conf_err, 1);

        send(HD, 16'h3000); send(PL, 16'd10); send(PL, 16'hAAAA); send(PL, 16'hBBBB);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid-packet reset conf_mem", conf_mem, 0);
        chk("mid-packet reset conf_err", conf_err, 0);

        e = '0;
        e[7] = 16'hC0DE;
        e[8] = 16'hF00D;
        gaps = 1'b1;
        exp_q.push_back(e);
        send(HD, 16'h3000); send(PL, 16'd7); send(PL, 16'hC0DE); send(LS, 16'hF00D);
        @(negedge clk);
        chk("gapped conf_mem", conf_mem, e);
        gaps = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(e);
        send(HD, 16'h3000); send(PL, 16'd7); send(PL, 16'hC0DE); send(LS, 16'hF00D);
        @(negedge clk);
        chk("gap-free conf_mem", conf_mem, e);

        repeat (2) @(negedge clk);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
